seq_det_ctrl: RTL and testbench

Frame-level controller for serial pattern detection. Accepts parallel words over a valid/ready handshake and serializes them MSB-first into a configurable-pattern matcher. It counts matches across a multi-word frame, with overlap or non-overlap semantics, and reports the total with a done pulse. It sits between a word-oriented producer and the bit-serial detector datapath, and owns frame start, bit sequencing, flush and result reporting.

---
 rtl/seq_det_ctrl_pkg.sv | 16 +
 rtl/seq_det_ctrl_if.sv | 34 +++
 rtl/seq_det_ctrl_pattern_matcher.sv | 48 ++++
 rtl/seq_det_ctrl.sv | 109 ++++++++++
 tb/tb_seq_det_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_det_ctrl_pkg.sv
// Shared types and default widths for the serial pattern-detect controller.
// Pure declarations: no timing, no handshake.
package seq_det_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_FLUSH = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_PAT_W  = 4;
  localparam int DEF_CNT_W  = 8;

endpackage

// File: rtl/seq_det_ctrl_if.sv
// Word-in / detect-out bundle between a word producer and seq_det_ctrl.
// No timing of its own; In_Valid/In_Ready is a plain valid/ready handshake.
interface seq_det_ctrl_if
  import seq_det_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PAT_W  = DEF_PAT_W,
  parameter int CNT_W  = DEF_CNT_W
);
  logic [PAT_W-1:0]  Cfg_Pat;
  logic              Cfg_Ovl;
  logic              In_Valid;
  logic [DATA_W-1:0] In_Data;
  logic              In_Last;
  logic              In_Ready;
  logic              Det_Bit;
  logic              Det_Valid;
  logic              Match;
  logic [CNT_W-1:0]  Match_Cnt;
  logic              Done;
  logic              Busy;
  state_t            State;

  modport master (
    output Cfg_Pat, Cfg_Ovl, In_Valid, In_Data, In_Last,
    input  In_Ready, Det_Bit, Det_Valid, Match, Match_Cnt, Done, Busy, State
  );

  modport slave (
    input  Cfg_Pat, Cfg_Ovl, In_Valid, In_Data, In_Last,
    output In_Ready, Det_Bit, Det_Valid, Match, Match_Cnt, Done, Busy, State
  );

endinterface

// File: rtl/seq_det_ctrl_pattern_matcher.sv
// Bit-serial PAT_W-bit pattern matcher with overlap/non-overlap semantics.
// Latency: Match one cycle after the completing bit; no backpressure (accepts a bit whenever Valid).
module pattern_matcher #(
  parameter int PAT_W = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Clr,
  input  logic             Bit,
  input  logic             Valid,
  input  logic [PAT_W-1:0] Pat,
  input  logic             Ovl,
  output logic             Match
);
  localparam int FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  hist;
  logic [PAT_W-1:0]  hist_nxt;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_nxt;
  logic              hit;

  always_comb begin
    hist_nxt = PAT_W'({hist, Bit});
    fill_nxt = (fill == FILL_W'(PAT_W)) ? fill : fill + 1'b1;
    hit      = Valid && (hist_nxt == Pat) && (fill_nxt == FILL_W'(PAT_W));
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      hist  <= '0;
      fill  <= '0;
      Match <= 1'b0;
    end else if (Clr) begin
      hist  <= '0;
      fill  <= '0;
      Match <= 1'b0;
    end else begin
      Match <= hit;
      if (Valid) begin
        hist <= hist_nxt;
        // Non-overlap: the matched bits may not seed the next match.
        fill <= (hit && !Ovl) ? '0 : fill_nxt;
      end
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Frame controller: serializes accepted words MSB-first into the matcher and counts matches per frame.
// Latency: DATA_W shift cycles per word (+1 bubble), +FLUSH/DONE on the last word; In_Ready only in IDLE.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PAT_W  = DEF_PAT_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input logic          Clk,
  input logic          Rst,
  seq_det_ctrl_if.slave bus
);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t            state;
  logic [DATA_W-1:0] sr;
  logic [IDX_W-1:0]  idx;
  logic              last_q;
  logic              busy;
  logic [PAT_W-1:0]  pat_q;
  logic              ovl_q;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              first;
  logic              det_vld;
  logic              det_bit;
  logic              match;

  assign accept  = bus.In_Valid && (state == ST_IDLE);
  assign first   = accept && !busy;
  assign det_vld = (state == ST_SHIFT);
  assign det_bit = det_vld & sr[DATA_W-1];

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state  <= ST_IDLE;
      sr     <= '0;
      idx    <= '0;
      last_q <= 1'b0;
      busy   <= 1'b0;
      pat_q  <= '0;
      ovl_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            sr     <= bus.In_Data;
            last_q <= bus.In_Last;
            idx    <= IDX_W'(DATA_W - 1);
            state  <= ST_SHIFT;
            // Config is frozen for the whole frame at its first word.
            if (!busy) begin
              busy  <= 1'b1;
              pat_q <= bus.Cfg_Pat;
              ovl_q <= bus.Cfg_Ovl;
            end
          end
        end
        ST_SHIFT: begin
          sr  <= sr << 1;
          idx <= idx - 1'b1;
          if (idx == '0) begin
            state <= last_q ? ST_FLUSH : ST_IDLE;
          end
        end
        ST_FLUSH: state <= ST_DONE;
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cnt <= '0;
    end else if (first) begin
      cnt <= '0;
    end else if (match && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  pattern_matcher #(
    .PAT_W (PAT_W)
  ) u_matcher (
    .Clk   (Clk),
    .Rst   (Rst),
    .Clr   (first),
    .Bit   (det_bit),
    .Valid (det_vld),
    .Pat   (pat_q),
    .Ovl   (ovl_q),
    .Match (match)
  );

  assign bus.In_Ready  = (state == ST_IDLE);
  assign bus.Det_Bit   = det_bit;
  assign bus.Det_Valid = det_vld;
  assign bus.Match     = match;
  assign bus.Match_Cnt = cnt;
  assign bus.Done      = (state == ST_DONE);
  assign bus.Busy      = busy;
  assign bus.State     = state;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl: vector table of single/two-word frames plus saturation, config and reset sequences.
module tb_seq_det_ctrl;

  typedef struct {
    logic [3:0]  pat;
    logic        ovl;
    logic [7:0]  w0;
    logic [7:0]  w1;
    int          nw;
    int          exp_cnt;
    logic [31:0] exp_trace;  // bit i: Match high in cycle T+i after first acceptance edge T
    int          exp_done;
  } vec_t;

  logic clk;
  logic rst;

  seq_det_ctrl_if #(.DATA_W(8), .PAT_W(4), .CNT_W(8)) bus ();

  seq_det_ctrl #(.DATA_W(8), .PAT_W(4), .CNT_W(8)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  words [0:63];
  logic [31:0] match_trace;
  int          done_cnt;
  int          done_cyc;
  logic [7:0]  cnt_at_done;
  logic        timed_out;
  int          mid_at = -1;
  logic [3:0]  mid_pat = 4'b0000;
  vec_t        vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives words[0..nw-1] back to back and records Match/Done timing relative to the first acceptance.
  task automatic run_frame(input logic [3:0] pat, input logic ovl, input int nw, input int max_cyc);
    int   t;
    int   w;
    logic acc;
    match_trace = '0;
    done_cnt    = 0;
    done_cyc    = -1;
    cnt_at_done = '0;
    timed_out   = 1'b1;
    @(posedge clk);
    #1;
    bus.Cfg_Pat  = pat;
    bus.Cfg_Ovl  = ovl;
    bus.In_Data  = words[0];
    bus.In_Last  = (nw == 1);
    bus.In_Valid = 1'b1;
    w = 0;
    t = -1;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if (t >= 1) begin
        if (bus.Match && t < 32) match_trace[t] = 1'b1;
        if (bus.Done) begin
          done_cnt++;
          if (done_cyc < 0) begin
            done_cyc    = t;
            cnt_at_done = bus.Match_Cnt;
          end
        end
      end
      if (done_cyc >= 0 && t >= done_cyc + 2) begin
        timed_out = 1'b0;
        break;
      end
      acc = bus.In_Valid && bus.In_Ready;
      @(posedge clk);
      #1;
      if (t >= 0) t++;
      if (acc) begin
        if (t < 0) t = 1;
        w++;
        if (w < nw) begin
          bus.In_Data = words[w];
          bus.In_Last = (w == nw - 1);
        end else begin
          bus.In_Valid = 1'b0;
        end
      end
      if (t == mid_at) bus.Cfg_Pat = mid_pat;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"},    32'(bus.State),     32'd0);
    check({tag, "_in_ready"}, 32'(bus.In_Ready),  32'd1);
    check({tag, "_det_bit"},  32'(bus.Det_Bit),   32'd0);
    check({tag, "_det_vld"},  32'(bus.Det_Valid), 32'd0);
    check({tag, "_match"},    32'(bus.Match),     32'd0);
    check({tag, "_cnt"},      32'(bus.Match_Cnt), 32'd0);
    check({tag, "_done"},     32'(bus.Done),      32'd0);
    check({tag, "_busy"},     32'(bus.Busy),      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'b1010, 1'b0, 8'hAA, 8'h00, 1, 2, (32'd1 << 5) | (32'd1 << 9), 10};
    vecs[1] = '{4'b1010, 1'b1, 8'hAA, 8'h00, 1, 3, (32'd1 << 5) | (32'd1 << 7) | (32'd1 << 9), 10};
    vecs[2] = '{4'b1010, 1'b0, 8'h0A, 8'hA0, 2, 2, (32'd1 << 9) | (32'd1 << 14), 19};
    vecs[3] = '{4'b1010, 1'b1, 8'h0A, 8'hA0, 2, 3, (32'd1 << 9) | (32'd1 << 12) | (32'd1 << 14), 19};
    vecs[4] = '{4'b1111, 1'b1, 8'hFF, 8'h00, 1, 5, 32'h0000_03E0, 10};
    vecs[5] = '{4'b1100, 1'b0, 8'h55, 8'h00, 1, 0, 32'h0, 10};
    vecs[6] = '{4'b0110, 1'b1, 8'h66, 8'h00, 1, 2, (32'd1 << 5) | (32'd1 << 9), 10};

    rst          = 1'b0;
    bus.In_Valid = 1'b0;
    bus.In_Data  = '0;
    bus.In_Last  = 1'b0;
    bus.Cfg_Pat  = '0;
    bus.Cfg_Ovl  = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      words[0] = vecs[i].w0;
      words[1] = vecs[i].w1;
      run_frame(vecs[i].pat, vecs[i].ovl, vecs[i].nw, 100);
      check($sformatf("v%0d_timeout", i),  32'(timed_out),   32'd0);
      check($sformatf("v%0d_trace", i),    match_trace,       vecs[i].exp_trace);
      check($sformatf("v%0d_cnt", i),      32'(cnt_at_done),  32'(vecs[i].exp_cnt));
      check($sformatf("v%0d_done_cyc", i), 32'(done_cyc),     32'(vecs[i].exp_done));
      check($sformatf("v%0d_done_n", i),   32'(done_cnt),     32'd1);
    end

    // 40 zero words against 0000 with overlap: 317 matches, counter must stop at 255.
    for (int i = 0; i < 40; i++) words[i] = 8'h00;
    run_frame(4'b0000, 1'b1, 40, 500);
    check("sat_timeout",  32'(timed_out),   32'd0);
    check("sat_cnt",      32'(cnt_at_done), 32'd255);
    check("sat_done_n",   32'(done_cnt),    32'd1);
    check("sat_done_cyc", 32'(done_cyc),    32'd361);
    check("sat_busy_end", 32'(bus.Busy),    32'd0);
    check("sat_cnt_hold", 32'(bus.Match_Cnt), 32'd255);

    // Pattern changed mid-frame must not affect the running frame.
    words[0] = 8'hAA;
    mid_at   = 3;
    mid_pat  = 4'b0000;
    run_frame(4'b1010, 1'b0, 1, 100);
    mid_at   = -1;
    check("cfg_cnt",      32'(cnt_at_done), 32'd2);
    check("cfg_done_cyc", 32'(done_cyc),    32'd10);
    words[0] = 8'h00;
    run_frame(4'b0000, 1'b0, 1, 100);
    check("cfg_next_cnt", 32'(cnt_at_done), 32'd2);

    // Reset in the second word of a running frame.
    bus.Cfg_Pat  = 4'b1010;
    bus.Cfg_Ovl  = 1'b1;
    bus.In_Data  = 8'hAA;
    bus.In_Last  = 1'b0;
    bus.In_Valid = 1'b1;
    @(posedge clk);
    repeat (12) @(posedge clk);
    #1;
    check("prerst_state", 32'(bus.State),     32'd1);
    check("prerst_cnt",   32'(bus.Match_Cnt), 32'd4);
    bus.In_Valid = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    begin
      int seen_done;
      seen_done = 0;
      repeat (3) begin
        @(negedge clk);
        if (bus.Done) seen_done++;
      end
      check("midrst_no_done", 32'(seen_done), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("postrst_cnt", 32'(bus.Match_Cnt), 32'd0);
    words[0] = 8'hAA;
    run_frame(4'b1010, 1'b0, 1, 100);
    check("postrst_timeout", 32'(timed_out),   32'd0);
    check("postrst_cnt_end", 32'(cnt_at_done), 32'd2);
    check("postrst_trace",   match_trace,      (32'd1 << 5) | (32'd1 << 9));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
